// File: rtl/he_pkg.sv
// he_pkg: frame geometry, luma coefficients and FSM encoding shared by the histogram-equalisation blocks.
package he_pkg;
    localparam int IMAGE_WIDTH  = 660;
    localparam int IMAGE_HEIGHT = 440;
    localparam int NUM_PIXELS   = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam logic [7:0] LUMA_R = 8'd77;
    localparam logic [7:0] LUMA_G = 8'd150;
    localparam logic [7:0] LUMA_B = 8'd29;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    typedef enum logic [1:0] {IDLE = ST_IDLE, READ = ST_READ, DRAIN = ST_DRAIN} state_t;
    // Coefficients sum to 256, so the 16-bit sum never wraps and the top byte is the luma.
    function automatic logic [7:0] luma(input logic [23:0] rgb);
        logic [15:0] s;
        s = 16'(LUMA_R) * 16'(rgb[23:16]) + 16'(LUMA_G) * 16'(rgb[15:8]) + 16'(LUMA_B) * 16'(rgb[7:0]);
        return s[15:8];
    endfunction
endpackage

// File: rtl/he_pixel_feeder_if.sv
// he_pixel_feeder_if: frame-memory read port plus luma pixel stream of the feeder.
interface he_pixel_feeder_if #(parameter int ADDR_W = 19);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [23:0]       mem_rdata;
    logic              pix_valid;
    logic              pix_ready;
    logic [7:0]        pix_data;
    logic              pix_last;
    modport master (output mem_rd, mem_addr, pix_valid, pix_data, pix_last, input mem_rdata, pix_ready);
    modport slave  (input mem_rd, mem_addr, pix_valid, pix_data, pix_last, output mem_rdata, pix_ready);
endinterface

// File: rtl/he_sync_fifo.sv
// he_sync_fifo: first-word-fall-through synchronous FIFO, power-of-two depth.
module he_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/he_pixel_feeder.sv
// he_pixel_feeder: streams one frame of RGB888 memory as 8-bit luma per start pulse.
module he_pixel_feeder #(
    parameter int IMAGE_WIDTH  = he_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = he_pkg::IMAGE_HEIGHT,
    parameter int ADDR_W       = 19,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    output logic busy,
    output logic frame_done,
    he_pixel_feeder_if.master bus
);
    import he_pkg::*;
    localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    state_t state, state_nx;
    logic [ADDR_W-1:0] addr;
    logic inflight, inflight_last, issue, at_last, pop, full, empty;
    logic [8:0] head;
    logic [CW-1:0] count;
    assign at_last = addr == ADDR_W'(NPIX - 1);
    // One read may be in flight, so reserve its slot before issuing another.
    assign issue = state == READ && !full && !(inflight && count == CW'(FIFO_DEPTH - 1));
    assign pop   = !empty && bus.pix_ready;
    assign bus.mem_rd    = issue;
    assign bus.mem_addr  = addr;
    assign bus.pix_valid = !empty;
    assign bus.pix_data  = empty ? 8'd0 : head[7:0];
    assign bus.pix_last  = !empty && head[8];
    he_sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (inflight),
        .din     ({inflight_last, luma(bus.mem_rdata)}),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );
    always_comb begin
        busy     = state != IDLE;
        state_nx = (state == IDLE && start && !frame_done) ? READ :
                   (state == READ && issue && at_last)     ? DRAIN :
                   (state == DRAIN && pop && head[8])      ? IDLE : state;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr          <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            addr          <= issue ? (at_last ? '0 : addr + 1'b1) : addr;
            inflight      <= issue;
            inflight_last <= issue && at_last;
            frame_done    <= state == DRAIN && state_nx == IDLE;
        end
    end
endmodule

// File: tb/tb_he_pixel_feeder.sv
// tb_he_pixel_feeder: scoreboard bench for the luma feeder on a reduced 16x8 frame.
module tb_he_pixel_feeder;
    localparam int W = 16, H = 8, N = W * H, DEPTH = 4, AW = 19;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic busy, frame_done;
    int checks = 0, errors = 0;
    int mode = 0, rd_exp = 0, rd_cnt = 0, nxfer = 0;
    logic [8:0] sb [$];
    logic exp_done = 1'b0, stall = 1'b0;
    logic [7:0] held = 8'd0;
    he_pixel_feeder_if #(.ADDR_W(AW)) bus ();
    he_pixel_feeder #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .bus        (bus)
    );
    always #5 clk = ~clk;
    function automatic logic [23:0] rgb_of(input int m, input int a);
        logic [23:0] colors [4];
        logic [7:0] v;
        colors = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};
        v = 8'(a);
        return m == 0 ? 24'h808080 : m == 1 ? colors[a % 4] : {v, v, v};
    endfunction
    function automatic logic [7:0] y_of(input int m, input int a);
        logic [7:0] ys [4];
        ys = '{8'd76, 8'd149, 8'd28, 8'd255};
        return m == 0 ? 8'd128 : m == 1 ? ys[a % 4] : 8'(a);
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    always @(posedge clk) bus.mem_rdata <= bus.mem_rd ? rgb_of(mode, int'(bus.mem_addr)) : 24'hx;
    always @(negedge clk) begin
        logic [8:0] e;
        logic e_last;
        e_last = 1'b0;
        if (!reset_n) begin
            exp_done = 1'b0;
            stall = 1'b0;
        end else begin
            chk("frame_done", 32'(frame_done), 32'(exp_done));
            if (stall) begin
                chk("hold_valid", 32'(bus.pix_valid), 32'd1);
                chk("hold_data", 32'(bus.pix_data), 32'(held));
            end
            if (bus.mem_rd) begin
                chk("mem_addr", 32'(bus.mem_addr), 32'(rd_exp));
                rd_exp = rd_exp == N - 1 ? 0 : rd_exp + 1;
                rd_cnt++;
            end
            if (bus.pix_valid && bus.pix_ready) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    e_last = e[8];
                    chk("pix_data", 32'(bus.pix_data), 32'(e[7:0]));
                    chk("pix_last", 32'(bus.pix_last), 32'(e[8]));
                end
                nxfer++;
            end
            exp_done = e_last;
            stall = bus.pix_valid && !bus.pix_ready;
            held = bus.pix_data;
        end
    end
    task automatic pulse_start(input bit accepted);
        @(posedge clk);
        #1 start = 1'b1;
        if (accepted) for (int a = 0; a < N; a++) sb.push_back({a == N - 1, y_of(mode, a)});
        @(posedge clk);
        #1 start = 1'b0;
    endtask
    task automatic run_frame(input bit rand_ready, input int limit);
        bit got;
        got = 1'b0;
        for (int c = 0; c < limit && !got; c++) begin
            @(posedge clk);
            #1 bus.pix_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
            @(negedge clk);
            got = frame_done;
        end
        chk("frame_done_seen", 32'(got), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask
    initial begin
        bit seen;
        bus.pix_ready = 1'b1;
        #2;
        chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        chk("rst_pix_data", 32'(bus.pix_data), 32'd0);
        chk("rst_pix_last", 32'(bus.pix_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        // constant grey frame, with first-pixel latency
        mode = 0;
        pulse_start(1'b1);
        @(negedge clk);
        chk("lat_c1_mem_rd", 32'(bus.mem_rd), 32'd1);
        chk("lat_c1_busy", 32'(busy), 32'd1);
        chk("lat_c1_valid", 32'(bus.pix_valid), 32'd0);
        @(negedge clk);
        chk("lat_c2_valid", 32'(bus.pix_valid), 32'd0);
        @(negedge clk);
        chk("lat_c3_valid", 32'(bus.pix_valid), 32'd1);
        run_frame(1'b0, 1000);
        chk("idle_after_frame", 32'(busy), 32'd0);
        // primary colours
        mode = 1;
        pulse_start(1'b1);
        run_frame(1'b0, 1000);
        // address ramp under random backpressure
        mode = 2;
        pulse_start(1'b1);
        run_frame(1'b1, 3000);
        // consumer stalled from the start
        @(posedge clk);
        #1 bus.pix_ready = 1'b0;
        rd_cnt = 0;
        pulse_start(1'b1);
        repeat (20) @(negedge clk);
        chk("stall_reads_le_depth", 32'(rd_cnt <= DEPTH), 32'd1);
        chk("stall_mem_rd_low", 32'(bus.mem_rd), 32'd0);
        chk("stall_valid", 32'(bus.pix_valid), 32'd1);
        run_frame(1'b0, 1000);
        // reset mid-frame
        nxfer = 0;
        pulse_start(1'b1);
        for (int c = 0; c < 1000 && nxfer < 100; c++) @(negedge clk);
        chk("reached_pixel_100", 32'(nxfer >= 100), 32'd1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("mid_rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("mid_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("mid_rst_valid", 32'(bus.pix_valid), 32'd0);
        chk("mid_rst_data", 32'(bus.pix_data), 32'd0);
        chk("mid_rst_last", 32'(bus.pix_last), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        sb.delete();
        rd_exp = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'd0);
        pulse_start(1'b1);
        run_frame(1'b0, 1000);
        // start while busy and coincident with frame_done
        pulse_start(1'b1);
        repeat (10) @(negedge clk);
        pulse_start(1'b0);
        seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge clk);
            seen = bus.pix_valid && bus.pix_ready && bus.pix_last;
        end
        chk("last_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #1 start = 1'b1;
        chk("start_at_done", 32'(frame_done), 32'd1);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("start_at_done_ignored", 32'(busy), 32'd0);
        chk("no_extra_reads", 32'(bus.mem_rd), 32'd0);
        pulse_start(1'b1);
        run_frame(1'b0, 1000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
